// File: rtl/multicast_router_hs_if.sv
`default_nettype none
// ============================================================================
// Module      : multicast_router_hs_if
// Description : Source, config and per-PE delivery bus of the multicast router.
// Revision    : 1.0 - initial release
// ============================================================================
interface multicast_router_hs_if #(
  parameter int PE_COUNT       = 5,
  parameter int DATA_WIDTH     = 16,
  parameter int ID_WIDTH       = 4,
  parameter int DROP_CNT_WIDTH = 8
);
  localparam int c_IDX_W = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1;

  logic [DATA_WIDTH-1:0]                in_val;
  logic [ID_WIDTH-1:0]                  tag_id;
  logic                                 in_valid;
  logic                                 in_ready;
  logic                                 cfg_we;
  logic [c_IDX_W-1:0]                   cfg_idx;
  logic [ID_WIDTH-1:0]                  cfg_id;
  logic [PE_COUNT-1:0][DATA_WIDTH-1:0]  out_vals;
  logic [PE_COUNT-1:0]                  out_valids;
  logic [PE_COUNT-1:0]                  out_readys;
  logic [DROP_CNT_WIDTH-1:0]            drop_cnt;

  // master: source, configuration agent and PE array side
  modport master (
    output in_val, tag_id, in_valid, cfg_we, cfg_idx, cfg_id, out_readys,
    input  in_ready, out_vals, out_valids, drop_cnt
  );

  modport slave (
    input  in_val, tag_id, in_valid, cfg_we, cfg_idx, cfg_id, out_readys,
    output in_ready, out_vals, out_valids, drop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/multicast_router_hs.sv
`default_nettype none
// ============================================================================
// Module      : multicast_router_hs
// Description : Latches one tagged word and delivers it to every PE whose ID
//               matches (all-ones tag broadcasts), with per-PE handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module multicast_router_hs #(
  parameter int PE_COUNT       = 5,
  parameter int DATA_WIDTH     = 16,
  parameter int ID_WIDTH       = 4,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  wire                      clk,
  input  wire                      rst,
  multicast_router_hs_if.slave     io_bus
);
  localparam int c_IDX_W = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_DELIVER = 1'b1
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [ID_WIDTH-1:0]        r_pe_id [PE_COUNT];
  logic [PE_COUNT-1:0]        r_pending;
  logic [PE_COUNT-1:0]        w_pending_next;
  logic [PE_COUNT-1:0]        w_match;
  logic [DATA_WIDTH-1:0]      r_data;
  logic [DROP_CNT_WIDTH-1:0]  r_drop;
  logic                       w_in_ready;
  logic                       w_accept;

  always_comb begin
    w_match = '0;
    for (int i = 0; i < PE_COUNT; i++) begin
      w_match[i] = (io_bus.tag_id == r_pe_id[i]) || (io_bus.tag_id == '1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Ready may follow out_readys combinationally so a draining word and the
  // next word share an edge without a bubble.
  always_comb begin
    w_in_ready     = 1'b1;
    w_pending_next = r_pending;
    w_state_next   = r_state;
    case (r_state)
      S_IDLE:    w_in_ready = 1'b1;
      S_DELIVER: w_in_ready = ((r_pending & ~io_bus.out_readys) == '0);
      default:   w_in_ready = 1'b1;
    endcase
    w_accept = io_bus.in_valid && w_in_ready;
    if (w_accept) begin
      w_pending_next = w_match;
    end else begin
      w_pending_next = r_pending & ~io_bus.out_readys;
    end
    w_state_next = (w_pending_next != '0) ? S_DELIVER : S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_data    <= '0;
      r_drop    <= '0;
    end else begin
      r_pending <= w_pending_next;
      if (w_accept) begin
        r_data <= io_bus.in_val;
        if ((w_match == '0) && (r_drop != '1)) begin
          r_drop <= r_drop + 1'b1;
        end
      end
    end
  end

  // Out-of-range indices never equal any loop index, so they are dropped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PE_COUNT; i++) begin
      if (rst) begin
        r_pe_id[i] <= ID_WIDTH'(i);
      end else if (io_bus.cfg_we && (io_bus.cfg_idx == c_IDX_W'(i))) begin
        r_pe_id[i] <= io_bus.cfg_id;
      end
    end
  end

  assign io_bus.in_ready   = w_in_ready;
  assign io_bus.out_valids = r_pending;
  assign io_bus.out_vals   = {PE_COUNT{r_data}};
  assign io_bus.drop_cnt   = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_multicast_router_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicast_router_hs
// Description : Directed and random stimulus against a per-PE reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicast_router_hs;
  localparam int PE_COUNT = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicast_router_hs_if #(
    .PE_COUNT(PE_COUNT), .DATA_WIDTH(16), .ID_WIDTH(4), .DROP_CNT_WIDTH(8)
  ) bus ();

  multicast_router_hs #(
    .PE_COUNT(PE_COUNT), .DATA_WIDTH(16), .ID_WIDTH(4), .DROP_CNT_WIDTH(8)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per-PE ID table, outstanding targets, held word, drops
  logic [3:0]  m_id   [PE_COUNT];
  bit          m_pend [PE_COUNT];
  logic [15:0] m_data;
  int          m_drop;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] pend_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < PE_COUNT; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic check_outputs();
    chk_eq("out_valids", 32'(bus.out_valids), pend_vec());
    for (int i = 0; i < PE_COUNT; i++) chk_eq("out_vals", 32'(bus.out_vals[i]), 32'(m_data));
    chk_eq("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
  endtask

  task automatic model_reset();
    for (int i = 0; i < PE_COUNT; i++) begin
      m_id[i]   = 4'(i);
      m_pend[i] = 1'b0;
    end
    m_data = '0;
    m_drop = 0;
  endtask

  task automatic drive_idle();
    bus.in_val = '0; bus.tag_id = '0; bus.in_valid = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_id = '0;
    bus.out_readys = '1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_outputs();
  endtask

  // One clock cycle: drive at negedge, check ready, advance model, check outputs
  task automatic step(input logic v, input logic [3:0] tag, input logic [15:0] d,
                      input logic we, input logic [2:0] idx, input logic [3:0] id,
                      input logic [4:0] rdy);
    bit exp_rdy;
    bit any;
    bit mask [PE_COUNT];
    bus.in_val = d; bus.tag_id = tag; bus.in_valid = v;
    bus.cfg_we = we; bus.cfg_idx = idx; bus.cfg_id = id;
    bus.out_readys = rdy;
    #1;
    exp_rdy = 1'b1;
    for (int i = 0; i < PE_COUNT; i++) if (m_pend[i] && !rdy[i]) exp_rdy = 1'b0;
    chk_eq("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (v && exp_rdy) begin
      any = 1'b0;
      for (int i = 0; i < PE_COUNT; i++) begin
        mask[i] = (tag == m_id[i]) || (tag == 4'hF);
        any |= mask[i];
        m_pend[i] = mask[i];
      end
      m_data = d;
      if (!any && m_drop < 255) m_drop++;
    end else begin
      for (int i = 0; i < PE_COUNT; i++) if (rdy[i]) m_pend[i] = 1'b0;
    end
    if (we && int'(idx) < PE_COUNT) m_id[idx] = id;
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    drive_idle();
    @(negedge clk);
    do_reset();
    chk_eq("reset_ready", 32'(bus.in_ready), 32'd1);

    // single unicast to PE2
    step(1, 4'd2, 16'hBEEF, 0, 0, 0, 5'h1F);
    chk_eq("uni_valids", 32'(bus.out_valids), 32'b00100);
    chk_eq("uni_data", 32'(bus.out_vals[4]), 32'hBEEF);
    step(0, 0, 0, 0, 0, 0, 5'h1F);
    chk_eq("uni_done", 32'(bus.out_valids), 32'd0);

    // broadcast with PE3 stalled; a competing word must wait
    step(1, 4'hF, 16'h1234, 0, 0, 0, 5'h1F);
    chk_eq("bc_valids", 32'(bus.out_valids), 32'h1F);
    for (int k = 0; k < 3; k++) begin
      step(1, 4'd0, 16'h5555, 0, 0, 0, 5'b10111);
      chk_eq("bc_stall", 32'(bus.out_valids), 32'b01000);
    end
    step(0, 0, 0, 0, 0, 0, 5'h1F);
    chk_eq("bc_data", 32'(bus.out_vals[0]), 32'h1234);

    // duplicate IDs, then a tag whose owner was reassigned is dropped
    step(0, 0, 0, 1, 3'd1, 4'd7, 5'h1F);
    step(0, 0, 0, 1, 3'd3, 4'd7, 5'h1F);
    step(1, 4'd7, 16'hA5A5, 0, 0, 0, 5'h1F);
    chk_eq("dup_valids", 32'(bus.out_valids), 32'b01010);
    step(1, 4'd1, 16'h0BAD, 0, 0, 0, 5'h1F);
    chk_eq("drop_one", 32'(bus.drop_cnt), 32'd1);

    // drop counter saturation
    for (int k = 0; k < 300; k++) step(1, 4'd9, 16'(k), 0, 0, 0, 5'h1F);
    chk_eq("drop_sat", 32'(bus.drop_cnt), 32'd255);

    // back-to-back streaming to PE0
    for (int k = 1; k <= 4; k++) begin
      step(1, 4'd0, 16'(k), 0, 0, 0, 5'b00001);
      chk_eq("stream_data", 32'(bus.out_vals[0]), 32'(k));
    end
    step(0, 0, 0, 0, 0, 0, 5'h1F);

    // reset while delivering restores IDs and counters
    step(1, 4'd2, 16'h7777, 0, 0, 0, 5'h00);
    do_reset();
    chk_eq("rst_valids", 32'(bus.out_valids), 32'd0);
    chk_eq("rst_drop", 32'(bus.drop_cnt), 32'd0);
    for (int k = 0; k < PE_COUNT; k++) begin
      step(1, 4'(k), 16'(16'h100 + k), 0, 0, 0, 5'h1F);
      chk_eq("rst_id", 32'(bus.out_valids), 32'(1) << k);
    end

    // random traffic, including out-of-range config writes
    for (int k = 0; k < 600; k++) begin
      step(1'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 9)),
           16'($urandom),
           1'($urandom_range(0, 7) == 0),
           3'($urandom_range(0, 7)),
           4'($urandom_range(0, 9)),
           5'($urandom | $urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
